vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48, horizontal porch and sync widths in pixel clocks.
REQ-003 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-004 Parameter V_FRONT / V_SYNC / V_BACK, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter SCALE_SHIFT, default 2, log2 of pixel replication in both axes (4x4 replication).
REQ-006 Parameter FB_WIDTH, default 160, framebuffer words per line.
REQ-007 Parameter FB_BASE, default 16'h0000, word address of framebuffer pixel (0,0).
REQ-008 Parameter RAM_LATENCY, default 2, clocks from address_vga to valid q_vga.
REQ-009 clock  input  1  pixel clock (25.175 MHz, the VGA-side RAM port clock).
REQ-010 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-011 address_vga  output  16  framebuffer read address to RAM port B.
REQ-012 q_vga  input  16  RAM port B read data; bits [11:8]=R, [7:4]=G, [3:0]=B, [15:12] ignored.
REQ-013 wren_vga  output  1  RAM port B write enable; constant 0.
REQ-014 data_vga  output  16  RAM port B write data; constant 0.
REQ-015 VGA_R / VGA_G / VGA_B  output  4 each  registered colour outputs.
REQ-016 VGA_HS / VGA_VS  output  1 each  registered sync outputs, active-low.
REQ-017 frame_start  output  1  one-clock pulse aligned with output pixel (0,0).

Function
REQ-018 hcount SHALL count 0..H_TOTAL-1 (H_TOTAL=800 default) every clock and wrap to 0; vcount SHALL increment on each hcount wrap, range 0..V_TOTAL-1 (525), wrapping to 0.
REQ-019 Visible region SHALL be hcount<H_VISIBLE and vcount<V_VISIBLE.
REQ-020 address_vga SHALL equal (line_base + (hcount >> SCALE_SHIFT)) mod 2^16 during visible cycles and SHALL hold its last value otherwise.
REQ-021 line_base SHALL load FB_BASE when vcount wraps to 0, and SHALL add FB_WIDTH at hcount wrap when vcount<V_VISIBLE and vcount[SCALE_SHIFT-1:0] is all ones; no multiplier SHALL be used.
REQ-022 Visible flag, HS and VS SHALL be delayed through a RAM_LATENCY-stage shift pipeline so that they align with q_vga.
REQ-023 Total latency from counter state (h,v) to VGA pins SHALL be RAM_LATENCY+1 clocks (3 default) for colour, sync and frame_start alike.
REQ-024 Colour outputs SHALL be q_vga[11:0] when the delayed visible flag is 1, else 0.
REQ-025 HS SHALL be low for hcount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751); VS low for vcount in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491).
REQ-026 frame_start SHALL be sampled at hcount=0 and vcount=0 and delayed per REQ-023.

Reset
REQ-027 While reset_n=0: hcount=0, vcount=0, line_base=FB_BASE, address_vga=FB_BASE, pipeline flags cleared, VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, frame_start=0.
REQ-028 Reset asserted mid-frame SHALL take effect immediately; after release, scanning SHALL restart at (0,0), and the first frame_start SHALL occur RAM_LATENCY+1 clocks after the first active clock edge.

Structure
REQ-029 Timing defaults (H/V visible, porch, sync) and derived H_TOTAL/V_TOTAL SHALL be localparams in shared package vga_pkg.
REQ-030 A sub-module vga_timing SHALL hold the hcount/vcount counters and raw visible/HS/VS decode; vga_scanout SHALL add the address generation and the delay pipeline.

Verification
REQ-031 Release reset, run one frame -> HS period 800 clocks, low 96 clocks; VS period 420000 clocks, low 1600 clocks; frame_start once per 420000 clocks.
REQ-032 RAM model latency 2, word at address a = a -> pixel (x=5, y=9) shows RGB = (2*160+1)[11:0] = 12'h141, with output delay 3 clocks from counter (5,9).
REQ-033 Lines 0..3 -> address_vga sequence 0,0,0,0,1,...,159 repeated each line; line 4 starts at 160; last visible address 19199.
REQ-034 FB_BASE=16'hFF00 -> addresses wrap modulo 2^16 past 16'hFFFF without glitch.
REQ-035 Assert reset_n low at (h=300, v=200) for 5 clocks -> outputs reach reset values in same cycle; after release, next frame_start after exactly 3 clocks.
REQ-036 Outside visible region, RAM returns 16'hFFFF -> RGB stays 0 throughout blanking.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing defaults, bus widths and the per-pixel
// scan-flag payload carried down the RAM-latency delay pipeline.
package vga_pkg;

  // Horizontal timing defaults, in pixel clocks.
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  // Vertical timing defaults, in lines.
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Counter width covers totals up to 4095 in either axis.
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned RGB_W  = 12;

  // Raw decode of one counter position; sync flags are active-high here.
  typedef struct packed {
    logic first;
    logic vsync;
    logic hsync;
    logic visible;
  } scan_flags_t;

  // True when cnt lies in [lo, lo+len).
  function automatic logic in_span(input logic [CNT_W-1:0] cnt,
                                   input int unsigned      lo,
                                   input int unsigned      len);
    return (cnt >= CNT_W'(lo)) && (cnt < CNT_W'(lo + len));
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running hcount/vcount raster counters with raw
// visible/HS/VS/first-pixel decode of the current position.
// Ports:
//   clock, reset_n     pixel clock, async active-low reset
//   vcount             current line (registered)
//   hcount_nxt_c       hcount value after the next edge (combinational)
//   vcount_nxt_c       vcount value after the next edge (combinational)
//   line_end_c         current cycle is the last of a line (combinational)
//   flags_c            raw decode of the current position (combinational)
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [CNT_W-1:0] vcount,
  output logic [CNT_W-1:0] hcount_nxt_c,
  output logic [CNT_W-1:0] vcount_nxt_c,
  output logic             line_end_c,
  output scan_flags_t      flags_c
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;

  // Next-position arithmetic: hcount wraps every line, vcount on each hcount wrap.
  always_comb begin
    hcount_d   = hcount_q + CNT_W'(1);
    vcount_d   = vcount_q;
    line_end_c = (hcount_q == CNT_W'(H_TOTAL - 1));
    if (line_end_c) begin
      hcount_d = '0;
      vcount_d = (vcount_q == CNT_W'(V_TOTAL - 1)) ? '0 : vcount_q + CNT_W'(1);
    end
  end

  // Raw decode of the current position.
  always_comb begin
    flags_c         = '0;
    flags_c.visible = (hcount_q < CNT_W'(H_VISIBLE)) && (vcount_q < CNT_W'(V_VISIBLE));
    flags_c.hsync   = in_span(hcount_q, H_VISIBLE + H_FRONT, H_SYNC);
    flags_c.vsync   = in_span(vcount_q, V_VISIBLE + V_FRONT, V_SYNC);
    flags_c.first   = (hcount_q == '0) && (vcount_q == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign vcount       = vcount_q;
  assign hcount_nxt_c = hcount_d;
  assign vcount_nxt_c = vcount_d;

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster scanout from a word-per-pixel framebuffer on a
// RAM read port, with 2^SCALE_SHIFT pixel replication in both axes.
// Ports:
//   clock, reset_n        pixel clock, async active-low reset
//   address_vga, q_vga    RAM port B read address / read data (RGB in [11:0])
//   wren_vga, data_vga    RAM port B write side, tied off
//   VGA_R/G/B             registered 4-bit colour, zero outside visible area
//   VGA_HS, VGA_VS        registered active-low syncs
//   frame_start           one-clock pulse aligned with output pixel (0,0)
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned       H_VISIBLE   = DEF_H_VISIBLE,
  parameter int unsigned       H_FRONT     = DEF_H_FRONT,
  parameter int unsigned       H_SYNC      = DEF_H_SYNC,
  parameter int unsigned       H_BACK      = DEF_H_BACK,
  parameter int unsigned       V_VISIBLE   = DEF_V_VISIBLE,
  parameter int unsigned       V_FRONT     = DEF_V_FRONT,
  parameter int unsigned       V_SYNC      = DEF_V_SYNC,
  parameter int unsigned       V_BACK      = DEF_V_BACK,
  parameter int unsigned       SCALE_SHIFT = 2,
  parameter int unsigned       FB_WIDTH    = 160,
  parameter logic [ADDR_W-1:0] FB_BASE     = 16'h0000,
  parameter int unsigned       RAM_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] address_vga,
  input  logic [DATA_W-1:0] q_vga,
  output logic              wren_vga,
  output logic [DATA_W-1:0] data_vga,
  output logic [3:0]        VGA_R,
  output logic [3:0]        VGA_G,
  output logic [3:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              frame_start
);

  // Low vcount bits all ones marks the last replicated line of a framebuffer row.
  localparam logic [CNT_W-1:0] SCALE_MASK = CNT_W'((1 << SCALE_SHIFT) - 1);

  logic [CNT_W-1:0] vcount;
  logic [CNT_W-1:0] hcount_nxt_c;
  logic [CNT_W-1:0] vcount_nxt_c;
  logic             line_end_c;
  scan_flags_t      flags_c;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clock        (clock),
    .reset_n      (reset_n),
    .vcount       (vcount),
    .hcount_nxt_c (hcount_nxt_c),
    .vcount_nxt_c (vcount_nxt_c),
    .line_end_c   (line_end_c),
    .flags_c      (flags_c)
  );

  logic [ADDR_W-1:0]                line_base_q, line_base_d;
  logic [ADDR_W-1:0]                address_q, address_d;
  logic                             visible_nxt;
  scan_flags_t [RAM_LATENCY-1:0]    pipe_q, pipe_d;
  scan_flags_t                      out_flags;
  logic [RGB_W-1:0]                 rgb_q, rgb_d;
  logic                             hs_n_q, hs_n_d;
  logic                             vs_n_q, vs_n_d;
  logic                             fs_q, fs_d;

  // Address generation is computed from the next counter position so the
  // registered address lines up with the counter state it belongs to; this
  // keeps the colour path at RAM_LATENCY+1 clocks, same as the flag pipeline.
  always_comb begin
    line_base_d = line_base_q;
    if (line_end_c) begin
      if (vcount_nxt_c == '0) begin
        line_base_d = FB_BASE;
      end else if ((vcount < CNT_W'(V_VISIBLE)) && ((vcount & SCALE_MASK) == SCALE_MASK)) begin
        line_base_d = line_base_q + ADDR_W'(FB_WIDTH);
      end
    end
    visible_nxt = (hcount_nxt_c < CNT_W'(H_VISIBLE)) && (vcount_nxt_c < CNT_W'(V_VISIBLE));
    address_d   = address_q;
    if (visible_nxt) begin
      address_d = line_base_d + ADDR_W'(hcount_nxt_c >> SCALE_SHIFT);
    end
  end

  // Flag delay line matching the RAM read latency, then the output register.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = flags_c;
    for (int i = 1; i < int'(RAM_LATENCY); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    out_flags = pipe_q[RAM_LATENCY-1];
    rgb_d     = out_flags.visible ? q_vga[RGB_W-1:0] : '0;
    hs_n_d    = ~out_flags.hsync;
    vs_n_d    = ~out_flags.vsync;
    fs_d      = out_flags.first;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_base_q <= FB_BASE;
      address_q   <= FB_BASE;
      pipe_q      <= '0;
      rgb_q       <= '0;
      hs_n_q      <= 1'b1;
      vs_n_q      <= 1'b1;
      fs_q        <= 1'b0;
    end else begin
      line_base_q <= line_base_d;
      address_q   <= address_d;
      pipe_q      <= pipe_d;
      rgb_q       <= rgb_d;
      hs_n_q      <= hs_n_d;
      vs_n_q      <= vs_n_d;
      fs_q        <= fs_d;
    end
  end

  assign address_vga = address_q;
  assign VGA_R       = rgb_q[11:8];
  assign VGA_G       = rgb_q[7:4];
  assign VGA_B       = rgb_q[3:0];
  assign VGA_HS      = hs_n_q;
  assign VGA_VS      = vs_n_q;
  assign frame_start = fs_q;
  assign wren_vga    = 1'b0;
  assign data_vga    = '0;

  // Upper RAM word bits carry no colour.
  logic unused_q_hi;
  assign unused_q_hi = ^q_vga[DATA_W-1:RGB_W];

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: drives a default-timing instance and a reduced-timing
// instance (wrapping framebuffer base) from a shared clock/reset, with
// latency-2 RAM models, and compares every output against a raster model
// computed directly from pixel positions.
module tb_vga_scanout;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb, sh, fbw, base;
  } tm_t;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } out_t;

  localparam int          LAT   = 3;
  localparam logic [15:0] KEY_D = 16'h0000;

  tm_t pd = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 160, 0};
  tm_t ps = '{64, 4, 8, 4, 24, 2, 2, 3, 2, 16, 32'hFFC0};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] key_s;
  int          cyc;
  int          total = 0;
  int          bad = 0;

  logic [15:0] d_addr, d_q, d_data, d_r1;
  logic        d_wren, d_hs, d_vs, d_fs;
  logic [3:0]  d_r, d_g, d_b;
  logic [15:0] s_addr, s_q, s_data, s_r1;
  logic        s_wren, s_hs, s_vs, s_fs;
  logic [3:0]  s_r, s_g, s_b;

  always #5 clock = ~clock;

  vga_scanout dut_d (
    .clock(clock), .reset_n(reset_n), .address_vga(d_addr), .q_vga(d_q),
    .wren_vga(d_wren), .data_vga(d_data), .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b),
    .VGA_HS(d_hs), .VGA_VS(d_vs), .frame_start(d_fs)
  );

  vga_scanout #(
    .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(24), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SCALE_SHIFT(2), .FB_WIDTH(16), .FB_BASE(16'hFFC0), .RAM_LATENCY(2)
  ) dut_s (
    .clock(clock), .reset_n(reset_n), .address_vga(s_addr), .q_vga(s_q),
    .wren_vga(s_wren), .data_vga(s_data), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .frame_start(s_fs)
  );

  // ---------------- reference model ----------------
  function automatic int ht(input tm_t p); return p.hv + p.hf + p.hs + p.hb; endfunction
  function automatic int vt(input tm_t p); return p.vv + p.vf + p.vs + p.vb; endfunction

  function automatic bit vis_at(input tm_t p, input int t);
    int pos = t % (ht(p) * vt(p));
    return ((pos % ht(p)) < p.hv) && ((pos / ht(p)) < p.vv);
  endfunction

  function automatic logic [15:0] pix_addr(input tm_t p, input int h, input int v);
    return 16'(p.base + (v >> p.sh) * p.fbw + (h >> p.sh));
  endfunction

  // Address on the RAM port t clocks after reset release (held in blanking).
  function automatic logic [15:0] exp_addr(input tm_t p, input int t);
    int pos = t % (ht(p) * vt(p));
    int h = pos % ht(p);
    int v = pos / ht(p);
    if (v >= p.vv) return pix_addr(p, p.hv - 1, p.vv - 1);
    if (h >= p.hv) return pix_addr(p, p.hv - 1, v);
    return pix_addr(p, h, v);
  endfunction

  // Pins t clocks after release show raster position t-LAT.
  function automatic out_t exp_out(input tm_t p, input int t, input logic [15:0] key);
    out_t o;
    int pos, h, v;
    o = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};
    if (t >= LAT) begin
      pos = (t - LAT) % (ht(p) * vt(p));
      h = pos % ht(p);
      v = pos / ht(p);
      if (h < p.hv && v < p.vv) o.rgb = 12'(pix_addr(p, h, v) ^ key);
      o.hs = !(h >= p.hv + p.hf && h < p.hv + p.hf + p.hs);
      o.vs = !(v >= p.vv + p.vf && v < p.vv + p.vf + p.vs);
      o.fs = (h == 0) && (v == 0);
    end
    return o;
  endfunction

  function automatic logic [15:0] blank_word();
    return ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
  endfunction

  function automatic out_t obs_d(); return {d_r, d_g, d_b, d_hs, d_vs, d_fs}; endfunction
  function automatic out_t obs_s(); return {s_r, s_g, s_b, s_hs, s_vs, s_fs}; endfunction

  // Clocks since reset release.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Latency-2 RAMs: word a holds a^key while visible, junk during blanking.
  always @(posedge clock) begin
    d_r1 <= vis_at(pd, cyc) ? (d_addr ^ KEY_D) : blank_word();
    d_q  <= d_r1;
    s_r1 <= vis_at(ps, cyc) ? (s_addr ^ key_s) : blank_word();
    s_q  <= s_r1;
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    out_t o;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    o = obs_d();
    total++; if (o !== exp_out(pd, 0, KEY_D)) begin bad++; $display("FAIL reset_out_d got=%h want=%h", o, exp_out(pd, 0, KEY_D)); end
    o = obs_s();
    total++; if (o !== exp_out(ps, 0, key_s)) begin bad++; $display("FAIL reset_out_s got=%h want=%h", o, exp_out(ps, 0, key_s)); end
    total++; if (d_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr_d got=%h want=0000", d_addr); end
    total++; if (s_addr !== 16'hFFC0) begin bad++; $display("FAIL reset_addr_s got=%h want=ffc0", s_addr); end
    total++; if ({d_wren, s_wren} !== 2'b00) begin bad++; $display("FAIL wren got=%b want=00", {d_wren, s_wren}); end
    total++; if ({d_data, s_data} !== 32'h0) begin bad++; $display("FAIL wdata got=%h want=0", {d_data, s_data}); end
  endtask

  task automatic test_scan();
    out_t o, e;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 7300; i++) begin
      @(negedge clock);
      o = obs_d(); e = exp_out(pd, cyc, KEY_D);
      total++; if (o !== e) begin bad++; $display("FAIL scan_out_d cyc=%0d got=%h want=%h", cyc, o, e); end
      total++; if (d_addr !== exp_addr(pd, cyc)) begin bad++; $display("FAIL scan_addr_d cyc=%0d got=%h want=%h", cyc, d_addr, exp_addr(pd, cyc)); end
      o = obs_s(); e = exp_out(ps, cyc, key_s);
      total++; if (o !== e) begin bad++; $display("FAIL scan_out_s cyc=%0d got=%h want=%h", cyc, o, e); end
      total++; if (s_addr !== exp_addr(ps, cyc)) begin bad++; $display("FAIL scan_addr_s cyc=%0d got=%h want=%h", cyc, s_addr, exp_addr(ps, cyc)); end
    end
  endtask

  task automatic test_sync_timing();
    logic p_shs, p_svs, p_sfs, p_dhs;
    int f_shs = -1, f_svs = -1, r_sfs = -1, f_dhs = -1, frames = 0;
    p_shs = s_hs; p_svs = s_vs; p_sfs = s_fs; p_dhs = d_hs;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clock);
      if (p_shs && !s_hs) begin
        if (f_shs >= 0) begin total++; if (cyc - f_shs != ht(ps)) begin bad++; $display("FAIL hs_period_s got=%0d want=%0d", cyc - f_shs, ht(ps)); end end
        f_shs = cyc;
      end
      if (!p_shs && s_hs && f_shs >= 0) begin total++; if (cyc - f_shs != ps.hs) begin bad++; $display("FAIL hs_low_s got=%0d want=%0d", cyc - f_shs, ps.hs); end end
      if (p_svs && !s_vs) begin
        if (f_svs >= 0) begin total++; if (cyc - f_svs != ht(ps) * vt(ps)) begin bad++; $display("FAIL vs_period_s got=%0d want=%0d", cyc - f_svs, ht(ps) * vt(ps)); end end
        f_svs = cyc;
      end
      if (!p_svs && s_vs && f_svs >= 0) begin total++; if (cyc - f_svs != ps.vs * ht(ps)) begin bad++; $display("FAIL vs_low_s got=%0d want=%0d", cyc - f_svs, ps.vs * ht(ps)); end end
      if (!p_sfs && s_fs) begin
        if (r_sfs >= 0) begin total++; if (cyc - r_sfs != ht(ps) * vt(ps)) begin bad++; $display("FAIL fs_period_s got=%0d want=%0d", cyc - r_sfs, ht(ps) * vt(ps)); end end
        r_sfs = cyc; frames++;
      end
      if (p_sfs && !s_fs) begin total++; if (cyc - r_sfs != 1) begin bad++; $display("FAIL fs_width_s got=%0d want=1", cyc - r_sfs); end end
      if (p_dhs && !d_hs) begin
        if (f_dhs >= 0) begin total++; if (cyc - f_dhs != ht(pd)) begin bad++; $display("FAIL hs_period_d got=%0d want=%0d", cyc - f_dhs, ht(pd)); end end
        f_dhs = cyc;
      end
      if (!p_dhs && d_hs && f_dhs >= 0) begin total++; if (cyc - f_dhs != pd.hs) begin bad++; $display("FAIL hs_low_d got=%0d want=%0d", cyc - f_dhs, pd.hs); end end
      p_shs = s_hs; p_svs = s_vs; p_sfs = s_fs; p_dhs = d_hs;
    end
    total++; if (frames < 2) begin bad++; $display("FAIL fs_count_s got=%0d want>=2", frames); end
  endtask

  task automatic test_pixel();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8000 && cyc < 7209; i++) begin
      if (cyc <= 4) begin
        total++; if (d_addr !== 16'(cyc >> 2)) begin bad++; $display("FAIL line0_addr cyc=%0d got=%0d want=%0d", cyc, d_addr, cyc >> 2); end
      end
      if (cyc == 2 || cyc == 3) begin
        total++; if (d_fs !== (cyc == 3)) begin bad++; $display("FAIL first_fs cyc=%0d got=%b want=%b", cyc, d_fs, cyc == 3); end
      end
      if (cyc == 4 * 800) begin
        total++; if (d_addr !== 16'd160) begin bad++; $display("FAIL line4_addr got=%0d want=160", d_addr); end
      end
      if (cyc == 9 * 800 + 2 + LAT) begin
        total++; if ({d_r, d_g, d_b} !== 12'h140) begin bad++; $display("FAIL pix_2_9 got=%h want=140", {d_r, d_g, d_b}); end
      end
      if (cyc == 9 * 800 + 5 + LAT) begin
        total++; if ({d_r, d_g, d_b} !== 12'h141) begin bad++; $display("FAIL pix_5_9 got=%h want=141", {d_r, d_g, d_b}); end
      end
      @(negedge clock);
    end
    total++; if (cyc < 7209) begin bad++; $display("FAIL pixel_timeout got=%0d want=7209", cyc); end
  endtask

  task automatic test_midframe_reset();
    out_t o, e;
    int target = 20 * ht(ps) + 30;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3000 && cyc != target; i++) @(negedge clock);
    total++; if (cyc != target) begin bad++; $display("FAIL mid_wait got=%0d want=%0d", cyc, target); end
    #1 reset_n = 1'b0;
    #1;
    o = obs_s();
    total++; if (o !== exp_out(ps, 0, key_s)) begin bad++; $display("FAIL mid_rst_out_s got=%h want=%h", o, exp_out(ps, 0, key_s)); end
    total++; if (s_addr !== 16'hFFC0) begin bad++; $display("FAIL mid_rst_addr_s got=%h want=ffc0", s_addr); end
    o = obs_d();
    total++; if (o !== exp_out(pd, 0, KEY_D)) begin bad++; $display("FAIL mid_rst_out_d got=%h want=%h", o, exp_out(pd, 0, KEY_D)); end
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (cyc == LAT) begin total++; if (s_fs !== 1'b1) begin bad++; $display("FAIL mid_first_fs got=%b want=1", s_fs); end end
      o = obs_s(); e = exp_out(ps, cyc, key_s);
      total++; if (o !== e) begin bad++; $display("FAIL mid_out_s cyc=%0d got=%h want=%h", cyc, o, e); end
      total++; if (s_addr !== exp_addr(ps, cyc)) begin bad++; $display("FAIL mid_addr_s cyc=%0d got=%h want=%h", cyc, s_addr, exp_addr(ps, cyc)); end
    end
  endtask

  task automatic test_random_reset();
    out_t o, e;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(50, 3000)) @(negedge clock);
      #1 reset_n = 1'b0;
      repeat ($urandom_range(1, 6)) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 120; i++) begin
        @(negedge clock);
        o = obs_s(); e = exp_out(ps, cyc, key_s);
        total++; if (o !== e) begin bad++; $display("FAIL rnd_out_s k=%0d cyc=%0d got=%h want=%h", k, cyc, o, e); end
        total++; if (s_addr !== exp_addr(ps, cyc)) begin bad++; $display("FAIL rnd_addr_s k=%0d cyc=%0d got=%h want=%h", k, cyc, s_addr, exp_addr(ps, cyc)); end
        o = obs_d(); e = exp_out(pd, cyc, KEY_D);
        total++; if (o !== e) begin bad++; $display("FAIL rnd_out_d k=%0d cyc=%0d got=%h want=%h", k, cyc, o, e); end
      end
    end
  endtask

  initial begin
    key_s = 16'($urandom);
    test_reset();
    test_scan();
    test_sync_timing();
    test_pixel();
    test_midframe_reset();
    test_random_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
